// File: rtl/axis_eth_ipv4_hdr_insert_pkg.sv
// Shared definitions for the Ethernet+IPv4 header insert block:
// FSM states, header geometry and the wire-order byte helper.
package axis_eth_ipv4_hdr_insert_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_MERGE  = 2'd2,
    ST_TAIL   = 2'd3
  } state_t;

  localparam int unsigned ETH_HDR_BYTES  = 14;
  localparam int unsigned IPV4_HDR_BYTES = 20;
  localparam int unsigned HDR_BYTES      = ETH_HDR_BYTES + IPV4_HDR_BYTES;
  localparam int unsigned HDR_BITS       = HDR_BYTES * 8;
  localparam int unsigned HDR_BEATS      = 4;
  localparam int unsigned HDR_TAIL_BYTES = 2;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

  // Converts a header written MSB-first (byte 0 in the top bits) into
  // wire order with byte 0 in bits [7:0], matching the AXIS lane layout.
  function automatic logic [HDR_BITS-1:0] to_wire_order(input logic [HDR_BITS-1:0] be);
    logic [HDR_BITS-1:0] wo;
    wo = '0;
    for (int unsigned i = 0; i < HDR_BYTES; i++) begin
      wo[8*i +: 8] = be[HDR_BITS-1-8*i -: 8];
    end
    return wo;
  endfunction

endpackage

// File: rtl/axis_eth_ipv4_hdr_insert_csum.sv
// IPv4 header checksum: one's-complement sum of the ten 16-bit header
// words with the checksum word taken as zero, folded twice, inverted.
module ipv4_hdr_csum
  import axis_eth_ipv4_hdr_insert_pkg::*;
(
  input  logic [5:0]  dscp,
  input  logic [1:0]  ecn,
  input  logic [15:0] length,
  input  logic [15:0] identifiant,
  input  logic [15:0] flags_fragmentoffset,
  input  logic [7:0]  ttl,
  input  logic [7:0]  protocol,
  input  logic [31:0] src_ipv4,
  input  logic [31:0] dest_ipv4,
  output logic [15:0] csum
);

  logic [15:0] words [10];
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Header words in transmit order; word 5 is the checksum slot itself.
  always_comb begin
    words[0] = {IPV4_VER_IHL, dscp, ecn};
    words[1] = length;
    words[2] = identifiant;
    words[3] = flags_fragmentoffset;
    words[4] = {ttl, protocol};
    words[5] = '0;
    words[6] = src_ipv4[31:16];
    words[7] = src_ipv4[15:0];
    words[8] = dest_ipv4[31:16];
    words[9] = dest_ipv4[15:0];
  end

  // Wide sum then two end-around carry folds; ten words fit in 20 bits.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      sum = sum + {4'b0, words[i]};
    end
    fold1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    fold2 = fold1[15:0] + {15'b0, fold1[16]};
    csum  = ~fold2;
  end

endmodule

// File: rtl/axis_eth_ipv4_hdr_insert.sv
// Builds a 34-byte Ethernet+IPv4 header from discrete fields and emits it
// on a 64-bit AXIS, followed by the payload shifted up by two byte lanes.
module axis_eth_ipv4_hdr_insert
  import axis_eth_ipv4_hdr_insert_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_hdr_valid,
  output logic                  s_hdr_ready,
  input  logic [47:0]           s_hdr_mac_dest,
  input  logic [47:0]           s_hdr_mac_src,
  input  logic [15:0]           s_hdr_ethtype,
  input  logic [5:0]            s_hdr_dscp,
  input  logic [1:0]            s_hdr_ecn,
  input  logic [15:0]           s_hdr_length,
  input  logic [15:0]           s_hdr_identifiant,
  input  logic [15:0]           s_hdr_flags_fragmentoffset,
  input  logic [7:0]            s_hdr_ttl,
  input  logic [7:0]            s_hdr_protocol,
  input  logic [31:0]           s_hdr_src_ipv4,
  input  logic [31:0]           s_hdr_dest_ipv4,
  input  logic [DATA_WIDTH-1:0] s_axis_payload_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_payload_tkeep,
  input  logic                  s_axis_payload_tvalid,
  output logic                  s_axis_payload_tready,
  input  logic                  s_axis_payload_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy
);

  if (DATA_WIDTH != 64) begin : g_bad_width
    $error("axis_eth_ipv4_hdr_insert supports DATA_WIDTH = 64 only");
  end

  state_t              state;
  logic [1:0]          beat;
  logic                first;
  logic [HDR_BITS-1:0] hdr;
  logic [15:0]         carry;
  logic [1:0]          carry_keep;

  logic [15:0]         csum;
  logic [HDR_BITS-1:0] hdr_be;
  logic [63:0]         hdr_word;
  logic                pay_xfer;
  logic                pay_spill;

  ipv4_hdr_csum u_csum (
    .dscp                 (s_hdr_dscp),
    .ecn                  (s_hdr_ecn),
    .length               (s_hdr_length),
    .identifiant          (s_hdr_identifiant),
    .flags_fragmentoffset (s_hdr_flags_fragmentoffset),
    .ttl                  (s_hdr_ttl),
    .protocol             (s_hdr_protocol),
    .src_ipv4             (s_hdr_src_ipv4),
    .dest_ipv4            (s_hdr_dest_ipv4),
    .csum                 (csum)
  );

  // Header image in MSB-first field order, checksum included.
  always_comb begin
    hdr_be = {s_hdr_mac_dest, s_hdr_mac_src, s_hdr_ethtype,
              IPV4_VER_IHL, s_hdr_dscp, s_hdr_ecn, s_hdr_length,
              s_hdr_identifiant, s_hdr_flags_fragmentoffset,
              s_hdr_ttl, s_hdr_protocol, csum,
              s_hdr_src_ipv4, s_hdr_dest_ipv4};
  end

  // Current header beat and payload handshake/spill decode.
  always_comb begin
    hdr_word  = hdr[{beat, 6'd0} +: 64];
    pay_xfer  = s_axis_payload_tvalid && m_axis_tready;
    pay_spill = s_axis_payload_tkeep[7:6] != 2'b00;
  end

  // Frame sequencer: header latch, header beats, payload merge, tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      beat       <= '0;
      first      <= 1'b0;
      hdr        <= '0;
      carry      <= '0;
      carry_keep <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (s_hdr_valid) begin
            hdr   <= to_wire_order(hdr_be);
            beat  <= '0;
            state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (m_axis_tready) begin
            beat <= beat + 2'd1;
            if (beat == 2'(HDR_BEATS - 1)) begin
              first <= 1'b1;
              state <= ST_MERGE;
            end
          end
        end
        ST_MERGE: begin
          if (pay_xfer) begin
            carry      <= s_axis_payload_tdata[63:48];
            carry_keep <= s_axis_payload_tkeep[7:6];
            first      <= 1'b0;
            if (s_axis_payload_tlast) begin
              state <= pay_spill ? ST_TAIL : ST_IDLE;
            end
          end
        end
        ST_TAIL: begin
          if (m_axis_tready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from registered state; MERGE passes payload valid/ready
  // straight through so the realigned stream has no bubbles.
  always_comb begin
    s_hdr_ready           = 1'b0;
    s_axis_payload_tready = 1'b0;
    m_axis_tvalid         = 1'b0;
    m_axis_tdata          = '0;
    m_axis_tkeep          = '0;
    m_axis_tlast          = 1'b0;
    busy                  = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        s_hdr_ready = 1'b1;
      end
      ST_HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = '1;
        m_axis_tdata  = hdr_word;
      end
      ST_MERGE: begin
        s_axis_payload_tready = m_axis_tready;
        m_axis_tvalid         = s_axis_payload_tvalid;
        m_axis_tdata          = {s_axis_payload_tdata[47:0],
                                 first ? hdr[HDR_BITS-1 -: 8*HDR_TAIL_BYTES] : carry};
        m_axis_tkeep          = {s_axis_payload_tkeep[5:0], 2'b11};
        m_axis_tlast          = s_axis_payload_tlast && !pay_spill;
      end
      ST_TAIL: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {48'b0, carry};
        m_axis_tkeep  = {6'b0, carry_keep};
        m_axis_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axis_eth_ipv4_hdr_insert.md
Name: axis_eth_ipv4_hdr_insert

Overview:
Transmit-side counterpart of the firewall's parse path. Accepts one Ethernet+IPv4 header as discrete fields over a valid/ready handshake, plus a payload AXI-Stream. Emits a complete 64-bit AXIS frame: 34 header bytes (14 Ethernet + 20 IPv4, IHL=5, checksum computed in the block) followed by the payload realigned by 2 bytes. Sits upstream of the data-processing top, feeding generated or rewritten packets into the TX path.

Parameters:
DATA_WIDTH, 64, stream width; fixed at 64, other values rejected at elaboration.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width.

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset (0 = reset)
s_hdr_valid  in  1  header fields valid
s_hdr_ready  out  1  header accepted when valid&ready
s_hdr_mac_dest  in  48  destination MAC
s_hdr_mac_src  in  48  source MAC
s_hdr_ethtype  in  16  EtherType, sent as given
s_hdr_dscp  in  6  DSCP
s_hdr_ecn  in  2  ECN
s_hdr_length  in  16  IPv4 total length, sent as given
s_hdr_identifiant  in  16  identification
s_hdr_flags_fragmentoffset  in  16  flags+fragment offset
s_hdr_ttl  in  8  TTL
s_hdr_protocol  in  8  protocol
s_hdr_src_ipv4  in  32  source IP
s_hdr_dest_ipv4  in  32  destination IP
s_axis_payload_tdata  in  64  payload data
s_axis_payload_tkeep  in  8  payload keep, contiguous from bit 0
s_axis_payload_tvalid  in  1
s_axis_payload_tready  out  1
s_axis_payload_tlast  in  1
m_axis_tdata  out  64  frame data
m_axis_tkeep  out  8
m_axis_tvalid  out  1
m_axis_tready  in  1
m_axis_tlast  out  1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; s_hdr_ready=1; m_axis_tvalid=0, tlast=0, tdata=0, tkeep=0; s_axis_payload_tready=0; busy=0; carry regs cleared. Reset mid-frame abandons the frame; no partial tail is emitted afterwards.
- Byte order: wire byte 0 is in tdata[7:0]. Multi-byte fields are big-endian on the wire, e.g. byte 0 = mac_dest[47:40], byte 12 = ethtype[15:8].
- IPv4 header words: 0x45 + {dscp,ecn}, length, id, flags_frag, {ttl,protocol}, checksum, src, dst.
- Checksum: 16-bit one's-complement sum of the 10 header words with the checksum word = 0. Fold the carry twice, then invert. Computed in the accept cycle and stored with the latched header.
- IDLE: s_hdr_ready=1. On s_hdr_valid, latch all fields and the checksum, go to HEADER with beat counter = 0.
- HEADER: m_axis_tvalid=1, tkeep=0xFF, tlast=0, data = header bytes 8k..8k+7. Counter advances on m_axis_tready. After beat 3 is accepted, go to MERGE with first=1. Latency from header accept to first output beat is 1 cycle.
- MERGE: s_axis_payload_tready = m_axis_tready; m_axis_tvalid = s_axis_payload_tvalid (combinational pass, no bubble).
  - First beat: data = {payload[47:0], hdr bytes 33,32}.
  - Later beats: data = {payload[47:0], carry[15:0]}.
  - tkeep = {payload_keep[5:0], 2'b11}.
  - On each transfer: carry <= payload[63:48], carry_keep <= payload_keep[7:6].
  - On a payload tlast transfer: if payload_keep[7:6] != 0, drive tlast=0 and go to TAIL; otherwise drive tlast=1 and go to IDLE.
- TAIL: m_axis_tvalid=1, data = {48'b0, carry}, tkeep = {6'b0, carry_keep}, tlast=1, s_axis_payload_tready=0. Go to IDLE on tready.
- AXIS rule: while tvalid && !tready, tdata/tkeep/tlast stay stable; payload is not consumed.
- s_hdr_ready=0 outside IDLE. A new header is accepted the cycle after the final beat, giving 1 idle cycle between frames.
- Payload presented in IDLE/HEADER is held (tready=0), never dropped. Payload minimum is 1 byte; tkeep=0 beats are not supported.

Decomposition:
- Shared package: state encoding (IDLE, HEADER, MERGE, TAIL), ETH_HDR_BYTES=14, IPV4_HDR_BYTES=20, HDR_BEATS=4, HDR_TAIL_BYTES=2, IPV4_VER_IHL=8'h45.
- One sub-module, ipv4_hdr_csum: combinational 10-word sum, double fold, invert.

Test Plan:
- Checksum vector: length=0x0073, id=0, flags=0x4000, ttl=0x40, proto=0x11, dscp/ecn=0, src=192.168.0.1, dst=192.168.0.199 -> header bytes 24,25 = 0xB8,0x61.
- 1-byte payload 0xAA -> 5 beats; beat 4 tkeep=0x07, byte 2 = 0xAA, tlast=1; busy falls after it.
- 6-byte payload -> 5 beats, beat 4 tkeep=0xFF, tlast=1. 7-byte payload -> 6 beats, last beat tkeep=0x01 holding payload byte 6.
- Random m_axis_tready backpressure (50%) over a 100-byte payload -> output bytes match the reference frame exactly; tdata stable while stalled.
- Reset asserted during MERGE -> all outputs at reset values immediately; the next header gives a clean frame with no residue.
- Back-to-back headers with s_hdr_valid held high -> second header accepted exactly 1 cycle after the first frame's tlast transfer.
